mem_ctrl: RTL and testbench

Byte-serial memory controller on the cache side of the RAM/IO bus. Responder for the dcache and icache miss/write-back protocol: accepts one byte request per cycle from either cache, issues it to the single-port RAM/IO bus, and returns a one-cycle acknowledge (with read data) on the following cycle. The dcache has strict priority over the icache. Fully pipelined, so a 4-byte line fill or write-back completes in 5 cycles.

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_ctrl_if.sv | 44 ++++
 rtl/mem_ctrl_arbiter.sv | 33 +++
 rtl/mem_ctrl.sv | 79 +++++++
 tb/tb_mem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial cache-side memory controller.
package mem_ctrl_pkg;

    localparam int DEFAULT_ADDR_W = 18;
    localparam int DEFAULT_BUS_AW = 32;
    localparam logic [1:0] IO_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_ICACHE = 2'd1,
        OWN_DCACHE = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Cache-side request/ack signals plus the RAM/IO bus, bundled for mem_ctrl.
interface mem_ctrl_if #(
    parameter int ADDR_W = mem_ctrl_pkg::DEFAULT_ADDR_W,
    parameter int BUS_AW = mem_ctrl_pkg::DEFAULT_BUS_AW
);
    logic              rdy;
    logic              io_buffer_full;

    logic              dcache_get_en;
    logic              dcache_write_mode;
    logic [ADDR_W-1:0] dcache_addr;
    logic [7:0]        dcache_data;
    logic              dcache_out_en;
    logic [7:0]        dcache_content;

    logic              icache_get_en;
    logic [ADDR_W-1:0] icache_addr;
    logic              icache_out_en;
    logic [7:0]        icache_content;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [BUS_AW-1:0] mem_a;
    logic              mem_wr;

    // The environment (caches + RAM) side.
    modport master (
        output rdy, io_buffer_full,
        output dcache_get_en, dcache_write_mode, dcache_addr, dcache_data,
        output icache_get_en, icache_addr, mem_din,
        input  dcache_out_en, dcache_content, icache_out_en, icache_content,
        input  mem_dout, mem_a, mem_wr
    );

    // The controller side.
    modport slave (
        input  rdy, io_buffer_full,
        input  dcache_get_en, dcache_write_mode, dcache_addr, dcache_data,
        input  icache_get_en, icache_addr, mem_din,
        output dcache_out_en, dcache_content, icache_out_en, icache_content,
        output mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl_arbiter.sv
// Fixed-priority grant (dcache over icache) with stall on rdy low or
// an IO write while the UART buffer is full.
module mem_ctrl_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic       i_rdy,
    input  logic       i_io_buffer_full,
    input  logic       i_dcache_get_en,
    input  logic       i_dcache_write_mode,
    input  logic [1:0] i_dcache_region,
    input  logic       i_icache_get_en,
    output owner_t     o_grant_owner,
    output logic       o_issue_en
);

    logic w_io_stall;

    assign w_io_stall = i_dcache_get_en && i_dcache_write_mode &&
                        (i_dcache_region == IO_PREFIX) && i_io_buffer_full;

    // A stalled dcache request keeps the grant, so the icache stays blocked.
    always_comb begin
        o_grant_owner = OWN_NONE;
        if (i_dcache_get_en) begin
            o_grant_owner = OWN_DCACHE;
        end else if (i_icache_get_en) begin
            o_grant_owner = OWN_ICACHE;
        end
    end

    assign o_issue_en = (o_grant_owner != OWN_NONE) && i_rdy && !w_io_stall;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: issues one cache byte per cycle to the
// RAM/IO bus and acknowledges it on the following cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int BUS_AW = DEFAULT_BUS_AW
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    owner_t            w_grant_owner;
    logic              w_issue_en;
    logic              w_issue;
    logic [ADDR_W-1:0] w_addr;
    logic              w_mem_wr;
    logic [7:0]        w_mem_dout;

    logic              r_pend_valid;
    owner_t            r_pend_owner;
    logic              r_pend_write;

    mem_ctrl_arbiter u_arbiter (
        .i_rdy               (bus.rdy),
        .i_io_buffer_full    (bus.io_buffer_full),
        .i_dcache_get_en     (bus.dcache_get_en),
        .i_dcache_write_mode (bus.dcache_write_mode),
        .i_dcache_region     (bus.dcache_addr[ADDR_W-1 -: 2]),
        .i_icache_get_en     (bus.icache_get_en),
        .o_grant_owner       (w_grant_owner),
        .o_issue_en          (w_issue_en)
    );

    // Gating with rst keeps mem_wr low for the whole reset window.
    assign w_issue = w_issue_en && !rst;

    always_comb begin
        w_addr     = '0;
        w_mem_wr   = 1'b0;
        w_mem_dout = '0;
        if (w_issue) begin
            if (w_grant_owner == OWN_DCACHE) begin
                w_addr     = bus.dcache_addr;
                w_mem_wr   = bus.dcache_write_mode;
                w_mem_dout = bus.dcache_data;
            end else begin
                w_addr     = bus.icache_addr;
            end
        end
    end

    assign bus.mem_a    = {{(BUS_AW-ADDR_W){1'b0}}, w_addr};
    assign bus.mem_wr   = w_mem_wr;
    assign bus.mem_dout = w_mem_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_owner <= OWN_NONE;
            r_pend_write <= 1'b0;
        end else begin
            r_pend_valid <= w_issue;
            r_pend_owner <= w_issue ? w_grant_owner : OWN_NONE;
            r_pend_write <= w_issue && (w_grant_owner == OWN_DCACHE) && bus.dcache_write_mode;
        end
    end

    // RAM read data arrives one cycle after issue, lining up with the ack.
    assign bus.dcache_out_en  = r_pend_valid && (r_pend_owner == OWN_DCACHE);
    assign bus.icache_out_en  = r_pend_valid && (r_pend_owner == OWN_ICACHE);
    assign bus.dcache_content = bus.mem_din;
    assign bus.icache_content = bus.mem_din;

    ap_write_owner: assert property (@(posedge clk) disable iff (rst)
        r_pend_write |-> (r_pend_owner == OWN_DCACHE));

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: each driven cycle pushes its expected bus
// activity and ack, popped and compared at the following negedge.
module tb_mem_ctrl;

    typedef struct {
        bit          rst, rdy, full, d_en, d_wr;
        logic [17:0] d_addr;
        logic [7:0]  d_data;
        bit          i_en;
        logic [17:0] i_addr;
    } stim_t;

    typedef struct {
        bit          bus_def;
        logic [31:0] a;
        bit          wr;
        logic [7:0]  dout;
        bit          d_ack, i_ack, chk;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        bit         valid, dc, rd;
        logic [7:0] data;
    } pend_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exp_t       exp_q[$];
    pend_t      m_pend;
    logic [7:0] shadow [logic [11:0]];
    logic [7:0] ram_w  [logic [11:0]];

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(logic [11:0] a);
        case (a)
            12'h100: return 8'h11;
            12'h101: return 8'h22;
            12'h102: return 8'h33;
            12'h103: return 8'h44;
            default: return 8'(a * 12'd7 + 12'd3);
        endcase
    endfunction

    // RAM/IO model: one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        bus.mem_din <= ram_w.exists(bus.mem_a[11:0]) ? ram_w[bus.mem_a[11:0]] : init_byte(bus.mem_a[11:0]);
        if (bus.mem_wr === 1'b1) ram_w[bus.mem_a[11:0]] = bus.mem_dout;
    end

    function automatic logic [7:0] shadow_rd(logic [11:0] a);
        return shadow.exists(a) ? shadow[a] : init_byte(a);
    endfunction

    function automatic stim_t st(bit r, bit rd, bit fl, bit de, bit dw, logic [17:0] da,
                                 logic [7:0] dd, bit ie, logic [17:0] ia);
        stim_t s;
        s.rst = r; s.rdy = rd; s.full = fl; s.d_en = de; s.d_wr = dw;
        s.d_addr = da; s.d_data = dd; s.i_en = ie; s.i_addr = ia;
        return s;
    endfunction

    function automatic stim_t idle_st();
        return st(0, 1, 0, 0, 0, 18'h0, 8'h0, 0, 18'h0);
    endfunction

    function automatic logic [58:0] obs_vec(exp_t e);
        return {bus.mem_a & {32{e.bus_def}}, bus.mem_wr, bus.mem_dout & {8{e.bus_def}},
                bus.dcache_out_en, bus.icache_out_en,
                bus.dcache_content & {8{e.chk}}, bus.icache_content & {8{e.chk}}};
    endfunction

    function automatic logic [58:0] exp_vec(exp_t e);
        return {e.a & {32{e.bus_def}}, e.wr, e.dout & {8{e.bus_def}}, e.d_ack, e.i_ack,
                e.data & {8{e.chk}}, e.data & {8{e.chk}}};
    endfunction

    // Drives one cycle and pushes what the controller must do in it.
    task automatic drive(input stim_t s);
        exp_t        e;
        pend_t       nxt;
        logic [11:0] ix;
        bit          blocked;
        @(posedge clk); #1;
        rst                   = s.rst;
        bus.rdy               = s.rdy;
        bus.io_buffer_full    = s.full;
        bus.dcache_get_en     = s.d_en;
        bus.dcache_write_mode = s.d_wr;
        bus.dcache_addr       = s.d_addr;
        bus.dcache_data       = s.d_data;
        bus.icache_get_en     = s.i_en;
        bus.icache_addr       = s.i_addr;
        if (s.rst) m_pend = '{default: 0};
        e = '{default: 0};
        e.bus_def = 1;
        e.d_ack = m_pend.valid && m_pend.dc;
        e.i_ack = m_pend.valid && !m_pend.dc;
        e.chk   = m_pend.valid && m_pend.rd;
        e.data  = m_pend.data;
        nxt = '{default: 0};
        blocked = s.rst || !s.rdy || (s.d_en && s.d_wr && s.d_addr[17:16] == 2'b11 && s.full);
        if ((s.d_en || s.i_en) && blocked) begin
            e.bus_def = 0;
        end else if (s.d_en) begin
            ix = s.d_addr[11:0];
            e.a = 32'(s.d_addr); e.wr = s.d_wr; e.dout = s.d_data;
            nxt = '{1, 1, !s.d_wr, shadow_rd(ix)};
            if (s.d_wr) shadow[ix] = s.d_data;
        end else if (s.i_en) begin
            ix = s.i_addr[11:0];
            e.a = 32'(s.i_addr);
            nxt = '{1, 0, 1, shadow_rd(ix)};
        end
        exp_q.push_back(e);
        m_pend = nxt;
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e;
        s.push_back(st(1, 1, 0, 0, 0, 18'h0, 8'h0, 0, 18'h0));
        s.push_back(st(1, 1, 0, 0, 0, 18'h0, 8'h0, 0, 18'h0));
        s.push_back(st(0, 1, 0, 1, 0, 18'h105, 8'h0, 0, 18'h0));
        s.push_back(idle_st());
        foreach (s[k]) begin
            drive(s[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_vec(e) !== exp_vec(e)) begin
                bad++;
                $display("[TB] FAIL reset cyc%0d got=%h want=%h", k, obs_vec(e), exp_vec(e));
            end
        end
    endtask

    task automatic test_read_burst();
        stim_t s[$];
        exp_t  e;
        int    acks = 0;
        for (int k = 0; k < 4; k++) s.push_back(st(0, 1, 0, 1, 0, 18'h100 + 18'(k), 8'h0, 0, 18'h0));
        s.push_back(idle_st());
        foreach (s[k]) begin
            drive(s[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_vec(e) !== exp_vec(e)) begin
                bad++;
                $display("[TB] FAIL read_burst cyc%0d got=%h want=%h", k, obs_vec(e), exp_vec(e));
            end
            if (bus.dcache_out_en === 1'b1) acks++;
        end
        total++;
        if (acks !== 4) begin
            bad++;
            $display("[TB] FAIL read_burst_acks got=%0d want=4", acks);
        end
    endtask

    task automatic test_writeback_fill();
        stim_t      s[$];
        exp_t       e;
        int         acks = 0;
        logic [7:0] wb[4];
        wb[0] = 8'hDD; wb[1] = 8'hCC; wb[2] = 8'hBB; wb[3] = 8'hAA;
        for (int k = 0; k < 4; k++) s.push_back(st(0, 1, 0, 1, 1, 18'h200 + 18'(k), wb[k], 0, 18'h0));
        for (int k = 0; k < 4; k++) s.push_back(st(0, 1, 0, 1, 0, 18'h300 + 18'(k), 8'h0, 0, 18'h0));
        s.push_back(idle_st());
        s.push_back(st(0, 1, 0, 1, 0, 18'h202, 8'h0, 0, 18'h0));
        s.push_back(idle_st());
        foreach (s[k]) begin
            drive(s[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_vec(e) !== exp_vec(e)) begin
                bad++;
                $display("[TB] FAIL writeback cyc%0d got=%h want=%h", k, obs_vec(e), exp_vec(e));
            end
            if (k < 9 && bus.dcache_out_en === 1'b1) acks++;
        end
        total++;
        if (acks !== 8) begin
            bad++;
            $display("[TB] FAIL writeback_acks got=%0d want=8", acks);
        end
    endtask

    task automatic test_icache_starve();
        stim_t s[$];
        exp_t  e;
        int    iacks = 0;
        for (int k = 0; k < 4; k++) s.push_back(st(0, 1, 0, 1, 0, 18'h100 + 18'(k), 8'h0, 1, 18'h010));
        s.push_back(st(0, 1, 0, 0, 0, 18'h0, 8'h0, 1, 18'h010));
        s.push_back(idle_st());
        foreach (s[k]) begin
            drive(s[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_vec(e) !== exp_vec(e)) begin
                bad++;
                $display("[TB] FAIL icache_starve cyc%0d got=%h want=%h", k, obs_vec(e), exp_vec(e));
            end
            if (bus.icache_out_en === 1'b1) iacks++;
        end
        total++;
        if (iacks !== 1) begin
            bad++;
            $display("[TB] FAIL icache_ack_count got=%0d want=1", iacks);
        end
    endtask

    task automatic test_io_full();
        stim_t s[$];
        exp_t  e;
        int    writes = 0;
        for (int k = 0; k < 3; k++) s.push_back(st(0, 1, 1, 1, 1, 18'h30000, 8'h5A, 1, 18'h040));
        s.push_back(st(0, 1, 0, 1, 1, 18'h30000, 8'h5A, 1, 18'h040));
        s.push_back(st(0, 1, 0, 0, 0, 18'h0, 8'h0, 1, 18'h040));
        s.push_back(idle_st());
        foreach (s[k]) begin
            drive(s[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_vec(e) !== exp_vec(e)) begin
                bad++;
                $display("[TB] FAIL io_full cyc%0d got=%h want=%h", k, obs_vec(e), exp_vec(e));
            end
            if (bus.mem_wr === 1'b1) writes++;
        end
        total++;
        if (writes !== 1) begin
            bad++;
            $display("[TB] FAIL io_write_count got=%0d want=1", writes);
        end
    endtask

    task automatic test_reset_inflight();
        stim_t s[$];
        exp_t  e;
        s.push_back(st(0, 1, 0, 0, 0, 18'h0, 8'h0, 1, 18'h020));
        s.push_back(st(1, 1, 0, 0, 0, 18'h0, 8'h0, 0, 18'h0));
        s.push_back(st(0, 1, 0, 1, 0, 18'h101, 8'h0, 0, 18'h0));
        s.push_back(idle_st());
        foreach (s[k]) begin
            drive(s[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_vec(e) !== exp_vec(e)) begin
                bad++;
                $display("[TB] FAIL reset_inflight cyc%0d got=%h want=%h", k, obs_vec(e), exp_vec(e));
            end
        end
    endtask

    task automatic test_rdy_low();
        stim_t s[$];
        exp_t  e;
        int    acks = 0;
        s.push_back(st(0, 1, 0, 1, 0, 18'h100, 8'h0, 0, 18'h0));
        s.push_back(st(0, 1, 0, 1, 0, 18'h101, 8'h0, 0, 18'h0));
        s.push_back(st(0, 0, 0, 1, 0, 18'h102, 8'h0, 0, 18'h0));
        s.push_back(st(0, 0, 0, 1, 0, 18'h102, 8'h0, 0, 18'h0));
        s.push_back(st(0, 1, 0, 1, 0, 18'h102, 8'h0, 0, 18'h0));
        s.push_back(st(0, 1, 0, 1, 0, 18'h103, 8'h0, 0, 18'h0));
        s.push_back(idle_st());
        foreach (s[k]) begin
            drive(s[k]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_vec(e) !== exp_vec(e)) begin
                bad++;
                $display("[TB] FAIL rdy_low cyc%0d got=%h want=%h", k, obs_vec(e), exp_vec(e));
            end
            if (bus.dcache_out_en === 1'b1) acks++;
        end
        total++;
        if (acks !== 4) begin
            bad++;
            $display("[TB] FAIL rdy_low_acks got=%0d want=4", acks);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        m_pend = '{default: 0};
        rst                   = 1'b1;
        bus.rdy               = 1'b1;
        bus.io_buffer_full    = 1'b0;
        bus.dcache_get_en     = 1'b0;
        bus.dcache_write_mode = 1'b0;
        bus.dcache_addr       = '0;
        bus.dcache_data       = '0;
        bus.icache_get_en     = 1'b0;
        bus.icache_addr       = '0;
        test_reset();
        test_read_burst();
        test_writeback_fill();
        test_icache_starve();
        test_io_full();
        test_reset_inflight();
        test_rdy_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
